// File: rtl/alu_op_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_driver_if
// Purpose  : Request/response and ALU-side signal bundle for alu_op_driver.
//            The "slave" modport is the driver's view; the "master" modport
//            is the environment's view (sequencer on the request/response
//            side and alu_32 on the ALU side).
// Revision : 1.0 - initial release
// ============================================================================
interface alu_op_driver_if #(
  parameter int WORD_SIZE           = 32,
  parameter int CONTROL_SIGNAL_SIZE = 4,
  parameter int COUNT_WIDTH         = 16
);

  // Request side
  logic                           req_valid;
  logic                           req_ready;
  logic [WORD_SIZE-1:0]           req_a;
  logic [WORD_SIZE-1:0]           req_b;
  logic [CONTROL_SIGNAL_SIZE-1:0] req_control;

  // ALU side
  logic                           alu_start;
  logic [WORD_SIZE-1:0]           alu_input_a;
  logic [WORD_SIZE-1:0]           alu_input_b;
  logic [CONTROL_SIGNAL_SIZE-1:0] alu_control;
  logic                           alu_finished;
  logic                           alu_zero;
  logic                           alu_cout;
  logic                           alu_err_overflow;
  logic                           alu_err_invalid_control;
  logic [WORD_SIZE-1:0]           alu_result;

  // Response side
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [WORD_SIZE-1:0]           rsp_result;
  logic                           rsp_zero;
  logic                           rsp_cout;
  logic                           rsp_overflow;
  logic                           rsp_invalid_control;
  logic                           rsp_timeout;

  // Status
  logic                           busy;
  logic [COUNT_WIDTH-1:0]         op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_control,
    output req_ready,
    output alu_start, alu_input_a, alu_input_b, alu_control,
    input  alu_finished, alu_zero, alu_cout, alu_err_overflow,
    input  alu_err_invalid_control, alu_result,
    output rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow,
    output rsp_invalid_control, rsp_timeout,
    input  rsp_ready,
    output busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_control,
    input  req_ready,
    input  alu_start, alu_input_a, alu_input_b, alu_control,
    output alu_finished, alu_zero, alu_cout, alu_err_overflow,
    output alu_err_invalid_control, alu_result,
    input  rsp_valid, rsp_result, rsp_zero, rsp_cout, rsp_overflow,
    input  rsp_invalid_control, rsp_timeout,
    output rsp_ready,
    input  busy, op_count
  );

endinterface
`default_nettype wire

// File: rtl/alu_op_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_driver
// Purpose  : Start/finished handshake initiator for alu_32. Latches a request,
//            presents operands one cycle before raising alu_start, waits for
//            alu_finished (with a completion timeout) and returns the captured
//            result and flags on a valid/ready response port. Counts completed
//            response handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_driver #(
  parameter int WORD_SIZE           = 32,
  parameter int CONTROL_SIGNAL_SIZE = 4,
  parameter int TIMEOUT_CYCLES      = 15,
  parameter int COUNT_WIDTH         = 16
) (
  input  wire logic         clock,
  input  wire logic         reset_n,
  alu_op_driver_if.slave    bus
);

  // Timer only needs to reach TIMEOUT_CYCLES-1 before the abort edge.
  localparam int c_timer_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_timer_w-1:0] r_timer;

  // Ready and busy are pure decodes of the state register.
  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);

  // Sequencer: accept, settle operands, start, wait/timeout, respond.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state                 <= S_IDLE;
      r_timer                 <= '0;
      bus.alu_start           <= 1'b0;
      bus.alu_input_a         <= '0;
      bus.alu_input_b         <= '0;
      bus.alu_control         <= '0;
      bus.rsp_valid           <= 1'b0;
      bus.rsp_result          <= '0;
      bus.rsp_zero            <= 1'b0;
      bus.rsp_cout            <= 1'b0;
      bus.rsp_overflow        <= 1'b0;
      bus.rsp_invalid_control <= 1'b0;
      bus.rsp_timeout         <= 1'b0;
      bus.op_count            <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            // Control codes are forwarded untouched; the ALU flags bad ones.
            bus.alu_input_a <= bus.req_a;
            bus.alu_input_b <= bus.req_b;
            bus.alu_control <= bus.req_control;
            r_state         <= S_SETUP;
          end
        end

        S_SETUP: begin
          // Operands have now been stable for a full cycle.
          bus.alu_start <= 1'b1;
          r_state       <= S_START;
        end

        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.alu_finished) begin
            // Completion has priority over a coincident timeout.
            bus.rsp_result          <= bus.alu_result;
            bus.rsp_zero            <= bus.alu_zero;
            bus.rsp_cout            <= bus.alu_cout;
            bus.rsp_overflow        <= bus.alu_err_overflow;
            bus.rsp_invalid_control <= bus.alu_err_invalid_control;
            bus.rsp_timeout         <= 1'b0;
            bus.rsp_valid           <= 1'b1;
            bus.alu_start           <= 1'b0;
            r_state                 <= S_RESP;
          end else if (r_timer == c_timer_last) begin
            bus.rsp_result          <= '0;
            bus.rsp_zero            <= 1'b0;
            bus.rsp_cout            <= 1'b0;
            bus.rsp_overflow        <= 1'b0;
            bus.rsp_invalid_control <= 1'b0;
            bus.rsp_timeout         <= 1'b1;
            bus.rsp_valid           <= 1'b1;
            bus.alu_start           <= 1'b0;
            r_state                 <= S_RESP;
          end else begin
            r_timer <= r_timer + c_timer_w'(1);
          end
        end

        S_RESP: begin
          // Response registers are left untouched until the consumer takes them.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.op_count  <= bus.op_count + COUNT_WIDTH'(1);
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_driver
// Purpose  : Self-checking bench for alu_op_driver. A behavioural alu_32
//            stand-in answers alu_start after a chosen delay; each operation's
//            expected response and latency are derived from the delay, the
//            timeout length and the ALU's arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_driver;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam int T  = 15;
  localparam int NW = 16;
  localparam int c_never = 1000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  alu_op_driver_if #(.WORD_SIZE(W), .CONTROL_SIGNAL_SIZE(CW), .COUNT_WIDTH(NW)) bus ();

  alu_op_driver #(
    .WORD_SIZE(W), .CONTROL_SIGNAL_SIZE(CW), .TIMEOUT_CYCLES(T), .COUNT_WIDTH(NW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural ALU ----------------
  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic        inv;
  } alu_out_t;

  function automatic alu_out_t alu_ref(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] c);
    alu_out_t    o;
    logic [32:0] s;
    o = '0;
    s = '0;
    case (c)
      4'h0: o.res = a & b;
      4'h1: o.res = a | b;
      4'h2: begin
        s     = {1'b0, a} + {1'b0, b};
        o.res = s[31:0];
        o.cout = s[32];
        o.ovf  = (a[31] == b[31]) && (o.res[31] != a[31]);
      end
      4'h6: begin
        s     = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.res = s[31:0];
        o.cout = s[32];
        o.ovf  = (a[31] != b[31]) && (o.res[31] != a[31]);
      end
      4'h7: o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC: o.res = ~(a | b);
      default: o.inv = 1'b1;
    endcase
    o.zero = !o.inv && (o.res == 32'd0);
    return o;
  endfunction

  alu_out_t mock;
  int       mock_delay = 0;
  bit       mock_stale = 1'b0;
  int       start_cnt  = 0;

  assign mock                        = alu_ref(bus.alu_input_a, bus.alu_input_b, bus.alu_control);
  assign bus.alu_result              = mock.res;
  assign bus.alu_zero                = mock.zero;
  assign bus.alu_cout                = mock.cout;
  assign bus.alu_err_overflow        = mock.ovf;
  assign bus.alu_err_invalid_control = mock.inv;
  // Finishes (3 + mock_delay) edges after accept; stale mode holds it high always.
  assign bus.alu_finished = mock_stale || (bus.alu_start && (start_cnt >= 2 + mock_delay));

  always @(posedge clock) begin
    #1;
    if (bus.alu_start) start_cnt = start_cnt + 1;
    else               start_cnt = 0;
  end

  // ---------------- reference model state ----------------
  int exp_count = 0;

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input int d, input bit stale, input int stall);
    alu_out_t    e;
    int          d_eff;
    bit          tmo;
    int          exp_lat;
    int          lat;
    bit          held_ok;
    d_eff   = stale ? 0 : d;
    tmo     = (d_eff > T - 1);
    exp_lat = tmo ? (2 + T) : (3 + d_eff);
    e       = tmo ? alu_out_t'(0) : alu_ref(a, b, c);

    @(negedge clock);
    mock_delay      = d;
    mock_stale      = stale;
    check_value({name, ".req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid   = 1'b1;
    bus.req_a       = a;
    bus.req_b       = b;
    bus.req_control = c;
    bus.rsp_ready   = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid   = 1'b0;
    bus.req_a       = $urandom;
    bus.req_b       = $urandom;
    bus.req_control = 4'($urandom);
    check_value({name, ".busy"}, 64'(bus.busy), 64'd1);

    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (lat == 1) begin
        check_value({name, ".start_rise"}, 64'(bus.alu_start), 64'd1);
        check_value({name, ".operands"},
                    {bus.alu_control, bus.alu_input_a, bus.alu_input_b[27:0]},
                    {c, a, b[27:0]});
      end
    end
    check_value({name, ".latency"}, 64'(lat), 64'(exp_lat));
    check_value({name, ".start_fall"}, 64'(bus.alu_start), 64'd0);
    check_value({name, ".result"}, 64'(bus.rsp_result), 64'(e.res));
    check_value({name, ".flags"},
                {59'd0, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow,
                 bus.rsp_invalid_control, bus.rsp_timeout},
                {59'd0, e.zero, e.cout, e.ovf, e.inv, tmo});

    held_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (!bus.rsp_valid || bus.rsp_result !== e.res || bus.req_ready !== 1'b0 ||
          bus.rsp_timeout !== tmo || bus.op_count !== NW'(exp_count))
        held_ok = 1'b0;
    end
    if (stall > 0) check_value({name, ".held"}, 64'(held_ok), 64'd1);

    bus.rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    exp_count     = (exp_count + 1) % (1 << NW);
    check_value({name, ".rsp_done"}, {bus.rsp_valid, bus.busy}, 2'b00);
    check_value({name, ".op_count"}, 64'(bus.op_count), 64'(exp_count));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: observed run still active expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] ctl_set [8];
    logic [3:0] c;
    int         d;
    int         r;
    bit         any_rsp;

    ctl_set = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h5, 4'hF};
    bus.req_valid   = 1'b0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.req_control = '0;
    bus.rsp_ready   = 1'b0;

    #1;
    check_value("rst.start_busy_valid", {bus.alu_start, bus.busy, bus.rsp_valid}, 3'b000);
    check_value("rst.inputs", {bus.alu_control, bus.alu_input_a, bus.alu_input_b}, '0);
    check_value("rst.rsp", {bus.rsp_result, bus.rsp_zero, bus.rsp_cout, bus.rsp_overflow,
                            bus.rsp_invalid_control, bus.rsp_timeout}, '0);
    check_value("rst.op_count", 64'(bus.op_count), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_value("rst.req_ready", 64'(bus.req_ready), 64'd1);

    run_op("add",     32'd5,         32'd7,         4'h2, 0,       1'b0, 0);
    run_op("sub_ovf", 32'h8000_0000, 32'd1,         4'h6, 0,       1'b0, 0);
    run_op("invalid", 32'h1234_5678, 32'h9ABC_DEF0, 4'h5, 2,       1'b0, 0);
    run_op("timeout", 32'd3,         32'd4,         4'h2, c_never, 1'b0, 0);
    run_op("bp_and",  32'hF0F0_F0F0, 32'hFF00_FF00, 4'h0, 1,       1'b0, 10);
    run_op("edge14",  32'd9,         32'd9,         4'h6, T - 1,   1'b0, 1);
    run_op("edge15",  32'd9,         32'd1,         4'h1, T,       1'b0, 0);
    run_op("stale",   32'hFFFF_FFFF, 32'd1,         4'h2, c_never, 1'b1, 2);

    // Reset while waiting for the ALU.
    @(negedge clock);
    mock_stale      = 1'b0;
    mock_delay      = c_never;
    bus.req_valid   = 1'b1;
    bus.req_a       = 32'd11;
    bus.req_b       = 32'd22;
    bus.req_control = 4'h2;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_value("rstw.start_busy", {bus.alu_start, bus.busy}, 2'b00);
    check_value("rstw.valid_count", {bus.rsp_valid, bus.op_count}, '0);
    exp_count = 0;
    @(negedge clock);
    reset_n = 1'b1;
    any_rsp = 1'b0;
    repeat (25) begin
      @(negedge clock);
      if (bus.rsp_valid || bus.busy) any_rsp = 1'b1;
    end
    check_value("rstw.no_rsp", 64'(any_rsp), 64'd0);
    run_op("after_rst", 32'd100, 32'd23, 4'h2, 1, 1'b0, 0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      c = ctl_set[$urandom_range(0, 7)];
      r = $urandom_range(0, 9);
      if (r < 6)      d = $urandom_range(0, 3);
      else if (r < 8) d = $urandom_range(T - 3, T + 1);
      else            d = c_never;
      run_op($sformatf("rnd%0d", n), $urandom, $urandom, c, d,
             ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_op_driver.md
# alu_op_driver

Synchronous initiator for the `alu_32` start/finished handshake. Accepts operation requests on a valid/ready port and latches operands and control onto the ALU inputs. It raises `alu_start`, waits for `alu_finished`, captures the result and flags, and returns them on a valid/ready response port. It sits between the datapath sequencer and `alu_32`, and adds a completion timeout and an operation counter.

## Interface
- `WORD_SIZE`, 32, operand/result width
- `CONTROL_SIGNAL_SIZE`, 4, ALU control width
- `TIMEOUT_CYCLES`, 15, WAIT-state edges without `alu_finished` before abort (min 1)
- `COUNT_WIDTH`, 16, width of `op_count`

Ports:
- `clock` in 1: single clock, all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: driver can accept a request
- `req_a`, `req_b` in WORD_SIZE: operands
- `req_control` in CONTROL_SIGNAL_SIZE: ALU function code
- `alu_start` out 1: to ALU `start`
- `alu_input_a`, `alu_input_b` out WORD_SIZE: registered operands to the ALU
- `alu_control` out CONTROL_SIGNAL_SIZE: registered control to the ALU
- `alu_finished`, `alu_zero`, `alu_cout`, `alu_err_overflow`, `alu_err_invalid_control` in 1: ALU status
- `alu_result` in WORD_SIZE: ALU result
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: consumer accepts response
- `rsp_result` out WORD_SIZE: captured result
- `rsp_zero`, `rsp_cout`, `rsp_overflow`, `rsp_invalid_control`, `rsp_timeout` out 1: captured flags
- `busy` out 1: state is not IDLE
- `op_count` out COUNT_WIDTH: completed response handshakes, wraps modulo 2^COUNT_WIDTH

## Operation
- States:
  - IDLE: `req_ready`=1.
  - SETUP: operands driven, `alu_start`=0.
  - START: `alu_start`=1.
  - WAIT: `alu_start`=1, timeout counter running.
  - RESP: `rsp_valid`=1.
- Transitions:
  - IDLE -> SETUP on `req_valid && req_ready`. The same edge loads `alu_input_a/b` and `alu_control` from `req_*`. They hold until the next accept.
  - SETUP -> START unconditionally. This guarantees operands are stable one full cycle before the `alu_start` rising edge.
  - START -> WAIT unconditionally. The timeout counter is cleared on this edge.
  - WAIT -> RESP on an edge where `alu_finished`=1.
    - Captures `alu_result`, `alu_zero`, `alu_cout`, `alu_err_overflow` and `alu_err_invalid_control` into the `rsp_*` registers.
    - Sets `rsp_timeout`=0.
  - WAIT -> RESP on the edge where the counter reaches TIMEOUT_CYCLES with `alu_finished`=0.
    - Sets `rsp_timeout`=1.
    - `rsp_result`=0 and all other `rsp_*` flags are 0.
  - If `alu_finished` is high on the timeout edge, completion wins: `rsp_timeout`=0.
  - RESP -> IDLE on `rsp_valid && rsp_ready`. `op_count` increments on that edge.
- `alu_start` is registered and drops to 0 on entry to RESP.
- `rsp_*` outputs hold stable while `rsp_valid`=1 and `rsp_ready`=0.
- `req_ready` is 0 outside IDLE. Only one operation is in flight at a time.
- A request with an undefined control code is forwarded unchanged. The ALU's `err_invalid_control` is reported through `rsp_invalid_control`.
- `busy` = (state != IDLE).

## Timing
- Reset (async assert, sync-safe deassert) forces, immediately:
  - state IDLE
  - `alu_start`=0
  - `alu_input_a/b`=0, `alu_control`=0
  - `rsp_valid`=0, all `rsp_*`=0
  - `op_count`=0, `busy`=0
  - `req_ready`=1 one cycle... no: `req_ready`=1 while reset is released and the state is IDLE
- Reset mid-operation discards the in-flight request. No response is produced and `op_count` is unchanged from 0.
- Latency, accept edge E0 to `rsp_valid`:
  - SETUP after E0, START after E1 (`alu_start` rises), WAIT after E2.
  - With `alu_finished` high at E3, `rsp_valid`=1 after E3: minimum 3 cycles.
- Timeout latency: `rsp_valid` after E(2+TIMEOUT_CYCLES). Default is E17.
- Throughput with `rsp_ready` held 1: one operation per 5 cycles (IDLE, SETUP, START, WAIT, RESP).
- `alu_finished` is sampled only in WAIT. A stale high level from a previous operation is ignored during SETUP and START.

## Test plan
- ADD 5+7: `req_control`=4'h2, a=5, b=7, ALU model finishes immediately.
  - `rsp_valid` 3 cycles after accept.
  - `rsp_result`=12, `rsp_zero`=0, `rsp_overflow`=0, `op_count`=1.
- SUB overflow: `req_control`=4'h6, a=32'h8000_0000, b=1.
  - `rsp_result`=32'h7FFF_FFFF, `rsp_overflow`=1.
- Invalid control: `req_control`=4'h5.
  - `rsp_invalid_control`=1, `rsp_timeout`=0.
- Timeout: `alu_finished` tied 0.
  - `rsp_timeout`=1 and `rsp_result`=0 at E17.
  - `alu_start` falls on the same edge.
- Backpressure: hold `rsp_ready`=0 for 10 cycles after `rsp_valid` with AND of 32'hF0F0_F0F0 and 32'hFF00_FF00.
  - `rsp_result`=32'hF000_F000 held stable throughout.
  - `req_ready`=0 throughout; `op_count` increments only on the release edge.
- Reset in WAIT: assert `reset_n`=0 mid-cycle.
  - `alu_start` and `busy` drop to 0 without waiting for a clock edge.
  - No `rsp_valid` afterwards; the next request completes normally.
